csmulti_arbiter: RTL and testbench
==================================

// Module: csmulti_arbiter
// PURPOSE
//  Shares one combinational carry save multiplier (csmulti_fullbasecell) between NREQ requesters.
//  - Round-robin arbiter grants one requester at a time and latches its operands.
//  - Operands are held stable for CALC_CYCLES clocks, so the array is a multicycle path.
//  - The product is registered and returned with the requester ID over a valid/ready handshake.
// PARAMETERS
//  BITSIZE      8  operand width; multiplier instance is csmulti_fullbasecell#(BITSIZE)
//  NREQ         4  number of requesters (>=2)
//  CALC_CYCLES  2  clocks the operands are held before the product is captured (>=1)
//  IDW (localparam) = max(1, $clog2(NREQ))
// PORTS
//  clk          in   1            system clock, rising edge
//  rst_n        in   1            reset, asynchronous, active-low
//  req_valid    in   NREQ         bit i: requester i has an operation pending
//  req_ready    out  NREQ         bit i: requester i granted; handshake completes this cycle
//  req_factor0  in   NREQ*BITSIZE requester i operand 0 at [i*BITSIZE +: BITSIZE]
//  req_factor1  in   NREQ*BITSIZE requester i operand 1 at [i*BITSIZE +: BITSIZE]
//  res_valid    out  1            result available
//  res_ready    in   1            consumer accepts result
//  res_product  out  2*BITSIZE    unsigned factor0*factor1
//  res_id       out  IDW          index of the requester that owns res_product
//  busy         out  1            high whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; res_valid=0; res_product=0; res_id=0
//   - last_grant=NREQ-1, so requester 0 has first priority
//   - counter=0; operand regs=0; req_ready forced to 0 while rst_n is low
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   IDLE:
//    - g = first i with req_valid[i]=1, searching (last_grant+1) mod NREQ upward with wrap
//    - req_ready = one-hot(g), combinational from state and req_valid; all zero if no valid
//    - On the clock edge: latch op0/op1/id from requester g; last_grant<=g;
//      cnt<=CALC_CYCLES-1; go to CALC
//   CALC:
//    - Multiplier inputs are op0/op1 regs only; req_ready=0
//    - If cnt==0: res_product<=mult_out; res_id<=id; res_valid<=1; go to DONE
//    - Otherwise cnt<=cnt-1
//   DONE:
//    - res_valid=1; res_product and res_id stable; req_ready=0
//    - On res_valid&res_ready: res_valid<=0; go to IDLE
//    - No new grant in this cycle
//  Latency and throughput:
//   - Accept in cycle T; res_valid first high in cycle T+CALC_CYCLES+1
//   - With res_ready tied high: one operation per CALC_CYCLES+2 cycles
//  Width: product is the full 2*BITSIZE unsigned result, never truncated or sign-extended.
//  Boundaries:
//   - req_valid deasserted before grant: no obligation; arbitration is re-evaluated every IDLE cycle.
//   - Requesters not granted are ignored; their valid may stay high; fairness comes from the rotating pointer.
//   - Single active requester is re-granted each round.
//   - res_ready high outside DONE: ignored.
//   - rst_n low mid-CALC or mid-DONE: operation aborted, result discarded, no res_valid pulse.
//     After release, arbitration restarts from requester 0.
//   - Operand changes by requesters after the handshake have no effect on the result.
// TESTING
//  T1 reset: assert rst_n low during CALC -> res_valid=0, busy=0, req_ready=0 immediately;
//     after release, req_valid=4'b1111 -> req_ready=4'b0001
//  T2 single op (defaults): req0 255*255 accepted cycle 0 -> res_valid cycle 3,
//     res_product=16'hFE01, res_id=0
//  T3 round robin: req_valid=4'b1111 held, res_ready=1 -> grant order 0,1,2,3,0;
//     products match the per-requester operands
//  T4 backpressure: res_ready=0 for 10 cycles in DONE -> res_valid, product and id stable;
//     req_ready=0; busy=1
//  T5 BITSIZE=4, CALC_CYCLES=1: 4'hF*4'h0 -> 8'h00 at latency 2; 4'hF*4'hF -> 8'hE1
//  T6 random: 1000 ops, random valids and res_ready -> every product equals a*b, ids correct,
//     no requester starved beyond NREQ grants

Source files
------------

// File: rtl/csmulti_arbiter.sv
// csmulti_arbiter: round-robin sharing of one carry-save array multiplier among
// NREQ requesters. The winner's operands are latched and held for CALC_CYCLES
// clocks (multicycle path through the array). The registered product is then
// returned with the requester id over a valid/ready handshake.

module csmulti_fullbasecell #(
    parameter int BITSIZE = 8
) (
    input  logic [BITSIZE-1:0]   factor0,
    input  logic [BITSIZE-1:0]   factor1,
    output logic [2*BITSIZE-1:0] product
);
    localparam int PW = 2 * BITSIZE;

    logic [PW-1:0] sum_s;
    logic [PW-1:0] carry_s;
    logic [PW-1:0] pp_s;
    logic [PW-1:0] nsum_s;
    logic [PW-1:0] ncarry_s;

    // Carry-save reduction: one full-adder row per multiplier bit, then a final carry-propagate add.
    // Carries out of the top bit are dropped. The true product fits in PW bits,
    // so the modulo-2^PW result is exact.
    always_comb begin
        sum_s    = '0;
        carry_s  = '0;
        pp_s     = '0;
        nsum_s   = '0;
        ncarry_s = '0;
        for (int i = 0; i < BITSIZE; i++) begin
            pp_s     = {{BITSIZE{1'b0}}, factor0 & {BITSIZE{factor1[i]}}} << i;
            nsum_s   = sum_s ^ carry_s ^ pp_s;
            ncarry_s = ((sum_s & carry_s) | (sum_s & pp_s) | (carry_s & pp_s)) << 1;
            sum_s    = nsum_s;
            carry_s  = ncarry_s;
        end
        product = sum_s + carry_s;
    end
endmodule

module csmulti_arbiter #(
    parameter int BITSIZE     = 8,
    parameter int NREQ        = 4,
    parameter int CALC_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*BITSIZE-1:0]   req_factor0,
    input  logic [NREQ*BITSIZE-1:0]   req_factor1,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [2*BITSIZE-1:0]      res_product,
    output logic [((($clog2(NREQ)) > 1) ? $clog2(NREQ) : 1)-1:0] res_id,
    output logic                      busy
);
    localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = ($clog2(CALC_CYCLES) > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  CNT_LOAD = CW'(CALC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BITSIZE-1:0]   op0_q, op0_d;
    logic [BITSIZE-1:0]   op1_q, op1_d;
    logic [IDW-1:0]       id_q, id_d;
    logic                 res_valid_q, res_valid_d;
    logic [2*BITSIZE-1:0] res_product_q, res_product_d;
    logic [IDW-1:0]       res_id_q, res_id_d;

    logic                 grant_found_s;
    logic [IDW-1:0]       grant_idx_s;
    logic [NREQ-1:0]      req_ready_s;
    logic [2*BITSIZE-1:0] mult_out_s;

    // The array only ever sees the latched operands, so its inputs are stable for the whole CALC window.
    csmulti_fullbasecell #(.BITSIZE(BITSIZE)) u_mult (
        .factor0 (op0_q),
        .factor1 (op1_q),
        .product (mult_out_s)
    );

    // Rotating-priority search starting one position past the previous grant.
    always_comb begin
        int cand;
        cand          = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!grant_found_s && req_valid[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IDW'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Next-state and datapath control for IDLE -> CALC -> DONE -> IDLE.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        op0_d         = op0_q;
        op1_d         = op1_q;
        id_d          = id_q;
        res_valid_d   = res_valid_q;
        res_product_d = res_product_q;
        res_id_d      = res_id_q;
        req_ready_s   = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    op0_d        = req_factor0[int'(grant_idx_s)*BITSIZE +: BITSIZE];
                    op1_d        = req_factor1[int'(grant_idx_s)*BITSIZE +: BITSIZE];
                    id_d         = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_q == {CW{1'b0}}) begin
                    res_product_d = mult_out_s;
                    res_id_d      = id_q;
                    res_valid_d   = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= LAST_RST;
            cnt_q         <= '0;
            op0_q         <= '0;
            op1_q         <= '0;
            id_q          <= '0;
            res_valid_q   <= 1'b0;
            res_product_q <= '0;
            res_id_q      <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            op0_q         <= op0_d;
            op1_q         <= op1_d;
            id_q          <= id_d;
            res_valid_q   <= res_valid_d;
            res_product_q <= res_product_d;
            res_id_q      <= res_id_d;
        end
    end

    // The grant is combinational, so it is gated directly by reset to stay quiet while rst_n is low.
    always_comb begin
        req_ready = req_ready_s & {NREQ{rst_n}};
    end

    assign res_valid   = res_valid_q;
    assign res_product = res_product_q;
    assign res_id      = res_id_q;
    assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_csmulti_arbiter.sv
// Scoreboard bench for csmulti_arbiter. A behavioural model predicts grants,
// result timing and products, and pushes the expected results into a queue.
// A separate monitor pops the queue and compares whenever a result is presented.
// A second small instance covers BITSIZE=4, CALC_CYCLES=1.
module tb_csmulti_arbiter;
    localparam int B = 8;
    localparam int N = 4;
    localparam int C = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*B-1:0] req_factor0 = '0;
    logic [N*B-1:0] req_factor1 = '0;
    logic           res_valid;
    logic           res_ready = 1'b0;
    logic [2*B-1:0] res_product;
    logic [1:0]     res_id;
    logic           busy;

    logic [1:0] b_req_valid = '0;
    logic [1:0] b_req_ready;
    logic [7:0] b_f0 = '0;
    logic [7:0] b_f1 = '0;
    logic       b_res_valid;
    logic       b_res_ready = 1'b1;
    logic [7:0] b_res_product;
    logic [0:0] b_res_id;
    logic       b_busy;

    csmulti_arbiter #(.BITSIZE(B), .NREQ(N), .CALC_CYCLES(C)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_factor0(req_factor0), .req_factor1(req_factor1), .res_valid(res_valid),
        .res_ready(res_ready), .res_product(res_product), .res_id(res_id), .busy(busy));

    csmulti_arbiter #(.BITSIZE(4), .NREQ(2), .CALC_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_factor0(b_f0), .req_factor1(b_f1), .res_valid(b_res_valid),
        .res_ready(b_res_ready), .res_product(b_res_product), .res_id(b_res_id), .busy(b_busy));

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] prod;
    } exp_t;

    exp_t     sb_q[$];
    int       checks = 0;
    int       errors = 0;
    int       cyc = 0;
    int       pops = 0;
    bit       model_en = 1'b0;
    bit       rand_en = 1'b0;
    int       m_ptr = N - 1;
    bit       m_pending = 1'b0;
    int       m_res_at = 0;
    bit [N-1:0] m_granted = '0;
    int       wg[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: rotating grant pointer plus arithmetic timing (result at accept+C+1, free after handshake).
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        bit   found;
        int   g;
        int   idx;
        exp_t e;
        if (!rst_n) begin
            m_ptr     = N - 1;
            m_pending = 1'b0;
            m_granted = '0;
            sb_q.delete();
            for (int j = 0; j < N; j++) wg[j] = 0;
        end else if (model_en) begin
            exp_rdy   = '0;
            found     = 1'b0;
            g         = 0;
            m_granted = '0;
            if (!m_pending) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        g     = idx;
                    end
                end
            end
            if (found) exp_rdy[g] = 1'b1;
            chk("busy", 32'(busy), 32'(m_pending));
            chk("res_valid", 32'(res_valid), 32'(m_pending && cyc >= m_res_at));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (m_pending && cyc >= m_res_at && res_ready) begin
                m_pending = 1'b0;
            end else if (found) begin
                e.id   = g;
                e.prod = 16'(req_factor0[g*B +: B]) * 16'(req_factor1[g*B +: B]);
                sb_q.push_back(e);
                for (int j = 0; j < N; j++) begin
                    if (j == g || !req_valid[j]) wg[j] = 0;
                    else begin
                        wg[j]++;
                        chk("starvation", 32'(wg[j] <= N - 1), 32'd1);
                    end
                end
                m_pending    = 1'b1;
                m_res_at     = cyc + C + 1;
                m_ptr        = g;
                m_granted[g] = 1'b1;
            end
        end
    end

    // Monitor: every presented result must match the oldest outstanding expectation, and stay put until taken.
    always @(negedge clk) begin
        if (rst_n && model_en && res_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                chk("res_product", 32'(res_product), 32'(sb_q[0].prod));
                chk("res_id", 32'(res_id), 32'(sb_q[0].id));
                if (res_ready) begin
                    void'(sb_q.pop_front());
                    pops++;
                end
            end
        end
    end

    function automatic logic [7:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 8'h00;
        else if (r == 1) return 8'hFF;
        else return 8'($urandom_range(0, 255));
    endfunction

    // Random requesters: hold valid and operands until granted, then pick a fresh request.
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            for (int i = 0; i < N; i++) begin
                if (m_granted[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_factor0[i*B +: B] = rand_op();
                    req_factor1[i*B +: B] = rand_op();
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_pops(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (pops < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(pops >= target), 32'd1);
    endtask

    initial begin
        int got[$];
        int ord[5];
        int p0;
        ord = '{0, 1, 2, 3, 0};

        // Reset state with all requesters asserting: no grant may leak out.
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_product", 32'(res_product), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);

        // Single 255*255 operation from requester 0.
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_en = 1'b1;
        req_valid = 4'b0001;
        req_factor0[7:0] = 8'hFF;
        req_factor1[7:0] = 8'hFF;
        res_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = '0;
        wait_pops(1, 20, "single_op_timeout");

        // Backpressure: result must be held while res_ready stays low.
        @(posedge clk); #1;
        req_valid = 4'b0010;
        req_factor0[15:8] = 8'h12;
        req_factor1[15:8] = 8'hAB;
        res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (C + 11) @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_pops(2, 20, "backpressure_timeout");

        // Reset in the middle of CALC aborts the operation.
        @(posedge clk); #1;
        req_valid = 4'b0100;
        req_factor0[23:16] = 8'h33;
        req_factor1[23:16] = 8'h44;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        chk("midcalc_res_valid", 32'(res_valid), 32'd0);
        chk("midcalc_busy", 32'(busy), 32'd0);
        chk("midcalc_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            req_factor0[i*B +: B] = 8'(8'h10 + i);
            req_factor1[i*B +: B] = 8'(8'hC0 + 3 * i);
        end
        rst_n = 1'b1;
        p0 = pops;

        // Round robin with all requesters held: order restarts from requester 0.
        for (int c = 0; c < 60 && got.size() < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (req_ready[i]) got.push_back(i);
        end
        chk("rr_grant_count", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5 && k < got.size(); k++) chk("rr_grant_order", 32'(got[k]), 32'(ord[k]));
        @(posedge clk); #1;
        req_valid = '0;
        wait_pops(p0 + 5, 60, "rr_drain_timeout");

        // Narrow instance: BITSIZE=4, CALC_CYCLES=1, latency 2.
        @(posedge clk); #1;
        b_req_valid = 2'b01;
        b_f0 = 8'h0F;
        b_f1 = 8'h00;
        @(negedge clk);
        chk("b_grant0", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 2'b00;
        @(negedge clk);
        chk("b_lat_early0", 32'(b_res_valid), 32'd0);
        @(negedge clk);
        chk("b_valid0", 32'(b_res_valid), 32'd1);
        chk("b_prod_F_0", 32'(b_res_product), 32'h00);
        chk("b_id0", 32'(b_res_id), 32'd0);
        @(posedge clk); #1;
        b_req_valid = 2'b10;
        b_f0 = 8'hF0;
        b_f1 = 8'hF0;
        @(negedge clk);
        chk("b_grant1", 32'(b_req_ready), 32'd2);
        @(posedge clk); #1;
        b_req_valid = 2'b00;
        @(negedge clk);
        chk("b_lat_early1", 32'(b_res_valid), 32'd0);
        @(negedge clk);
        chk("b_valid1", 32'(b_res_valid), 32'd1);
        chk("b_prod_F_F", 32'(b_res_product), 32'hE1);
        chk("b_id1", 32'(b_res_id), 32'd1);

        // Randomised traffic: 1000 operations with random valids and backpressure.
        p0 = pops;
        @(posedge clk); #1;
        rand_en = 1'b1;
        wait_pops(p0 + 1000, 30000, "random_timeout");
        rand_en = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        res_ready = 1'b1;
        repeat (10) @(posedge clk);
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
